cdc_counter: RTL and testbench



---
 rtl/cdc_counter_pkg.sv | 24 ++
 rtl/cdc_counter_data_sequencer.sv | 42 ++++
 rtl/cdc_counter.sv | 64 ++++++
 tb/tb_cdc_counter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cdc_counter_pkg.sv
// ============================================================================
// Module      : cdc_counter_pkg
// Description : Shared Gray-code and pointer-width helpers for the FIFO CDC
//               pointer counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdc_counter_pkg;

    localparam int c_MAX_PTR_W = 32;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Reflected binary Gray code; callers cast the result down to pointer width.
    function automatic logic [c_MAX_PTR_W-1:0] gray_of(input logic [c_MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_counter_data_sequencer.sv
// ============================================================================
// Module      : data_sequencer
// Description : DEPTH-stage register chain used to carry a Gray pointer into
//               the destination clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sequencer #(
    parameter int BITWIDTH = 1,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] dIN,
    output logic [BITWIDTH-1:0] dOUT
);
    import cdc_counter_pkg::*;

    logic [BITWIDTH-1:0] r_stage_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_stage_q[gi] <= '0;
                    else     r_stage_q[gi] <= dIN;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) r_stage_q[gi] <= '0;
                    else     r_stage_q[gi] <= r_stage_q[gi-1];
                end
            end
        end
    endgenerate

    assign dOUT = r_stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/cdc_counter.sv
// ============================================================================
// Module      : cdc_counter
// Description : Binary/Gray pointer counter with full (write side) or empty
//               (read side) detection against a synchronised peer pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_counter
    import cdc_counter_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter bit FULLCHECK = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Count_en,
    input  logic [addr_width(DEPTH):0]    ComparisonPointer,
    output logic                          PointerMatch,
    output logic [addr_width(DEPTH):0]    GreyPointer,
    output logic [addr_width(DEPTH)-1:0]  BinaryPointer
);
    localparam int ADDRWIDTH = addr_width(DEPTH);
    localparam int PW        = ADDRWIDTH + 1;

    logic [PW-1:0] r_bin_q, r_bin_d;
    logic [PW-1:0] r_gray_q, r_gray_d;
    logic [PW-1:0] w_match_ref;

    always_comb begin
        r_bin_d  = r_bin_q;
        if (Count_en) r_bin_d = r_bin_q + 1'b1;
        r_gray_d = PW'(gray_of(c_MAX_PTR_W'(r_bin_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin_q  <= '0;
            r_gray_q <= '0;
        end else begin
            r_bin_q  <= r_bin_d;
            r_gray_q <= r_gray_d;
        end
    end

    // Full: peer is exactly one lap behind, which in Gray means the top two bits invert.
    generate
        if (!FULLCHECK) begin : g_empty
            assign w_match_ref = ComparisonPointer;
        end else if (ADDRWIDTH == 1) begin : g_full_narrow
            assign w_match_ref = ~ComparisonPointer;
        end else begin : g_full
            assign w_match_ref = {~ComparisonPointer[ADDRWIDTH:ADDRWIDTH-1],
                                  ComparisonPointer[ADDRWIDTH-2:0]};
        end
    endgenerate

    assign PointerMatch  = (r_gray_q == w_match_ref);
    assign GreyPointer   = r_gray_q;
    assign BinaryPointer = r_bin_q[ADDRWIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_cdc_counter.sv
// ============================================================================
// Module      : tb_cdc_counter
// Description : Directed self-checking bench for cdc_counter (both flag
//               polarities) and data_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic [2:0] cmp0 = 3'b000, cmp1 = 3'b000;
    logic       match0, match1;
    logic [2:0] grey0, grey1;
    logic [1:0] bin0, bin1;
    logic [2:0] ds_din = 3'b000;
    logic [2:0] ds_dout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cdc_counter #(.DEPTH(4), .FULLCHECK(1'b0)) u_empty (
        .clk(clk), .rst(rst), .Count_en(en0), .ComparisonPointer(cmp0),
        .PointerMatch(match0), .GreyPointer(grey0), .BinaryPointer(bin0)
    );

    cdc_counter #(.DEPTH(4), .FULLCHECK(1'b1)) u_full (
        .clk(clk), .rst(rst), .Count_en(en1), .ComparisonPointer(cmp1),
        .PointerMatch(match1), .GreyPointer(grey1), .BinaryPointer(bin1)
    );

    data_sequencer #(.BITWIDTH(3), .DEPTH(2)) u_seq (
        .clk(clk), .rst(rst), .dIN(ds_din), .dOUT(ds_dout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en0 = 1'b1; en1 = 1'b1; cmp0 = 3'b000; cmp1 = 3'b000;
        step(); step();
        rst = 1'b0; en0 = 1'b0; en1 = 1'b0;
        #1;
        n_cmp++; if (grey0 !== 3'b000) begin n_fail++; $display("FAIL reset_grey0: got %b want 000", grey0); end
        n_cmp++; if (bin0 !== 2'd0)    begin n_fail++; $display("FAIL reset_bin0: got %0d want 0", bin0); end
        n_cmp++; if (match0 !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %b want 1", match0); end
        n_cmp++; if (match1 !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b want 0", match1); end
        n_cmp++; if (grey1 !== 3'b000) begin n_fail++; $display("FAIL reset_grey1: got %b want 000", grey1); end
        n_cmp++; if (ds_dout !== 3'b000) begin n_fail++; $display("FAIL reset_seq: got %b want 000", ds_dout); end
    endtask

    task automatic test_count_wrap();
        logic [2:0] exp_g [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        logic [1:0] exp_b [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        en0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (grey0 !== exp_g[i]) begin n_fail++; $display("FAIL count_grey[%0d]: got %b want %b", i, grey0, exp_g[i]); end
            n_cmp++; if (bin0 !== exp_b[i])  begin n_fail++; $display("FAIL count_bin[%0d]: got %0d want %0d", i, bin0, exp_b[i]); end
        end
        en0 = 1'b0;
        step();
        n_cmp++; if (grey0 !== 3'b000) begin n_fail++; $display("FAIL count_hold: got %b want 000", grey0); end
    endtask

    task automatic test_full();
        cmp1 = 3'b000; en1 = 1'b1;
        step(); step(); step();
        n_cmp++; if (match1 !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b want 0 (grey %b)", match1, grey1); end
        step();
        en1 = 1'b0;
        n_cmp++; if (grey1 !== 3'b110) begin n_fail++; $display("FAIL full_grey: got %b want 110", grey1); end
        n_cmp++; if (match1 !== 1'b1)  begin n_fail++; $display("FAIL full_set: got %b want 1", match1); end
        cmp1 = 3'b001; #1;
        n_cmp++; if (match1 !== 1'b0)  begin n_fail++; $display("FAIL full_clear: got %b want 0", match1); end
    endtask

    task automatic test_empty();
        en0 = 1'b1;
        step(); step(); step();
        en0 = 1'b0;
        cmp0 = 3'b010; #1;
        n_cmp++; if (grey0 !== 3'b010) begin n_fail++; $display("FAIL empty_grey: got %b want 010", grey0); end
        n_cmp++; if (match0 !== 1'b1)  begin n_fail++; $display("FAIL empty_set: got %b want 1", match0); end
        cmp0 = 3'b110; #1;
        n_cmp++; if (match0 !== 1'b0)  begin n_fail++; $display("FAIL empty_clear: got %b want 0", match0); end
    endtask

    task automatic test_reset_midcount();
        en0 = 1'b1;
        step(); step();
        n_cmp++; if (grey0 !== 3'b111 || bin0 !== 2'd1) begin n_fail++; $display("FAIL mid_b5: got %b/%0d want 111/1", grey0, bin0); end
        rst = 1'b1;
        step();
        n_cmp++; if (grey0 !== 3'b000 || bin0 !== 2'd0) begin n_fail++; $display("FAIL mid_rst: got %b/%0d want 000/0", grey0, bin0); end
        rst = 1'b0;
        step();
        en0 = 1'b0;
        n_cmp++; if (grey0 !== 3'b001 || bin0 !== 2'd1) begin n_fail++; $display("FAIL mid_resume: got %b/%0d want 001/1", grey0, bin0); end
    endtask

    task automatic test_sequencer();
        ds_din = 3'b011;
        step();
        n_cmp++; if (ds_dout !== 3'b000) begin n_fail++; $display("FAIL seq_edge1: got %b want 000", ds_dout); end
        step();
        n_cmp++; if (ds_dout !== 3'b011) begin n_fail++; $display("FAIL seq_edge2: got %b want 011", ds_dout); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (ds_dout !== 3'b000) begin n_fail++; $display("FAIL seq_rst: got %b want 000", ds_dout); end
        step();
        n_cmp++; if (ds_dout !== 3'b000) begin n_fail++; $display("FAIL seq_rst_stage0: got %b want 000", ds_dout); end
        step();
        n_cmp++; if (ds_dout !== 3'b011) begin n_fail++; $display("FAIL seq_refill: got %b want 011", ds_dout); end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_full();
        test_empty();
        test_reset_midcount();
        test_sequencer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
